// File: rtl/fmv_pkg.sv
// FMV frame-writer shared types and constants.
// Also used by map_fmv for frame sizing.
package fmv_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_BUF,
    ST_GET_HI,
    ST_GET_LO,
    ST_WR,
    ST_TRAILER,
    ST_COMMIT,
    ST_DRAIN
  } fmv_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int FMV_WORD_BYTES = 2;
  localparam int FMV_CRC_BYTES  = 2;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic [7:0]  b
  );
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = (c << 1) ^ CRC_POLY;
      else       c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/fmv_frame_writer_crc16.sv
// Byte-wide CRC-16/CCITT accumulator.
// Only instantiated when FMV_CRC_EN is defined.
module fmv_crc16
  import fmv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // Running CRC: restart per frame, fold in each accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc16_step(crc, data);
  end

endmodule

// File: rtl/fmv_frame_writer.sv
// FMV producer: byte stream -> 68k words -> ping-pong frames.
// Optional CRC trailer check enabled by FMV_CRC_EN.
module fmv_frame_writer
  import fmv_pkg::*;
#(
  parameter int                ADDR_W      = 23,
  parameter int                FRAME_WORDS = 16384,
  parameter logic [ADDR_W-1:0] BASE0       = 'h000000,
  parameter logic [ADDR_W-1:0] BASE1       = 'h004000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [1:0]        buf_full,
  input  logic [1:0]        buf_release,
  output logic              wr_buf,
  output logic [15:0]       frame_cnt,
  output logic              err_len,
  output logic              err_crc
);

  localparam int IW = $clog2(FRAME_WORDS) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);

  fmv_state_e  state, state_nxt;
  logic [IW-1:0] idx;
  logic [7:0]  hi;
  logic        last_word;
  logic        hi_ld, wr_go, wr_done;
  logic        idx_clr, commit, len_err;
  logic [1:0]  buf_full_nxt;

`ifdef FMV_CRC_EN
  logic [15:0] crc;
  logic        trl_hi;
  logic        crc_clr, crc_en;
  logic        crc_err, trl_ld;

  fmv_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .data  (s_data),
    .crc   (crc)
  );
`endif

  assign last_word = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT_BUF;
    else        state <= state_nxt;
  end

  // Next state, handshake and datapath strobes
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    hi_ld     = 1'b0;
    wr_go     = 1'b0;
    wr_done   = 1'b0;
    idx_clr   = 1'b0;
    commit    = 1'b0;
    len_err   = 1'b0;
`ifdef FMV_CRC_EN
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_err   = 1'b0;
    trl_ld    = 1'b0;
`endif
    unique case (state)
      ST_WAIT_BUF: begin
        if (!buf_full[wr_buf]) begin
          idx_clr   = 1'b1;
`ifdef FMV_CRC_EN
          crc_clr   = 1'b1;
`endif
          state_nxt = ST_GET_HI;
        end
      end
      ST_GET_HI: begin
        s_ready = 1'b1;
        if (s_valid) begin
`ifdef FMV_CRC_EN
          crc_en = 1'b1;
`endif
          if (s_last) begin
            len_err   = 1'b1;
            state_nxt = ST_WAIT_BUF;
          end else begin
            hi_ld     = 1'b1;
            state_nxt = ST_GET_LO;
          end
        end
      end
      ST_GET_LO: begin
        s_ready = 1'b1;
        if (s_valid) begin
`ifdef FMV_CRC_EN
          crc_en = 1'b1;
          if (s_last) begin
            len_err   = 1'b1;
            state_nxt = ST_WAIT_BUF;
          end else begin
            wr_go     = 1'b1;
            state_nxt = ST_WR;
          end
`else
          if (last_word && !s_last) begin
            len_err   = 1'b1;
            state_nxt = ST_DRAIN;
          end else if (!last_word && s_last) begin
            len_err   = 1'b1;
            state_nxt = ST_WAIT_BUF;
          end else begin
            wr_go     = 1'b1;
            state_nxt = ST_WR;
          end
`endif
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          wr_done = 1'b1;
          if (last_word) begin
`ifdef FMV_CRC_EN
            state_nxt = ST_TRAILER;
`else
            state_nxt = ST_COMMIT;
`endif
          end else begin
            state_nxt = ST_GET_HI;
          end
        end
      end
`ifdef FMV_CRC_EN
      ST_TRAILER: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (!trl_hi) begin
            if (s_last) begin
              len_err   = 1'b1;
              state_nxt = ST_WAIT_BUF;
            end else begin
              trl_ld    = 1'b1;
            end
          end else if (!s_last) begin
            len_err   = 1'b1;
            state_nxt = ST_DRAIN;
          end else if ({hi, s_data} == crc) begin
            state_nxt = ST_COMMIT;
          end else begin
            crc_err   = 1'b1;
            state_nxt = ST_WAIT_BUF;
          end
        end
      end
`endif
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_WAIT_BUF;
      end
      ST_DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = ST_WAIT_BUF;
      end
      default: state_nxt = ST_WAIT_BUF;
    endcase
  end

  // Word index and high-byte holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      hi  <= '0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (wr_done) idx <= idx + IW'(1);
`ifdef FMV_CRC_EN
      if (hi_ld || trl_ld) hi <= s_data;
`else
      if (hi_ld) hi <= s_data;
`endif
    end
  end

  // Memory write port: request held stable until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (wr_go) begin
      mem_req  <= 1'b1;
      mem_addr <= (wr_buf ? BASE1 : BASE0) + ADDR_W'(idx);
      mem_data <= {hi, s_data};
    end else if (wr_done) begin
      mem_req  <= 1'b0;
    end
  end

  // Release clears a flag; a same-cycle commit to that buffer wins
  always_comb begin
    buf_full_nxt = buf_full & ~buf_release;
    if (commit) buf_full_nxt[wr_buf] = 1'b1;
  end

  // Buffer ownership, frame counter, length error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full  <= '0;
      wr_buf    <= 1'b0;
      frame_cnt <= '0;
      err_len   <= 1'b0;
    end else begin
      buf_full <= buf_full_nxt;
      err_len  <= len_err;
      if (commit) begin
        wr_buf    <= ~wr_buf;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef FMV_CRC_EN
  // Trailer byte phase and CRC error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trl_hi  <= 1'b0;
      err_crc <= 1'b0;
    end else begin
      err_crc <= crc_err;
      if (idx_clr)     trl_hi <= 1'b0;
      else if (trl_ld) trl_hi <= 1'b1;
    end
  end
`else
  assign err_crc = 1'b0;
`endif

endmodule
